// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and helpers for the DDR write-data path.
//   burst_size_t : bytes-per-word encoding (1<<size bytes).
//   beat_period  : clk cycles between burst_to_byte loads for a word size,
//                  max(1, bytes/2), because DQ moves 2 bytes per clk.
//   WL_MIN/WL_MAX: legal write-latency range in cycles.
package ddr_pkg;

  typedef enum logic [1:0] {
    BS_1B = 2'd0,
    BS_2B = 2'd1,
    BS_4B = 2'd2,
    BS_8B = 2'd3
  } burst_size_t;

  // The minimum latency is one cycle to reach the first counting cycle plus
  // the two-cycle lead of a pool read ahead of its start pulse.
  localparam int WL_MIN = 3;
  localparam int WL_MAX = 15;

  function automatic logic [2:0] beat_period(input burst_size_t size);
    case (size)
      BS_4B:   return 3'd2;
      BS_8B:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/wdata_beat_timer.sv
// wdata_beat_timer: read/start schedule for one write command.
// Reads are due at cycle WRITE_LATENCY-2 after acceptance and then every
// period cycles, one per word; each start is the read delayed by two cycles.
// Ports:
//   clk, n_rst  : clock, async active-low reset
//   load        : command accepted this cycle (restarts the schedule)
//   abort       : underrun this cycle; cancels all outstanding reads/starts
//   beats_m1    : words in the command minus one (sampled on load)
//   period      : cycles between words (held by the caller for the command)
//   rd_due      : a pool pop is due this cycle
//   start_soon  : a start is due next cycle
//   start_due   : a start is due this cycle
//   start_last  : the due start carries the final word
module wdata_beat_timer
  import ddr_pkg::*;
#(
  parameter int WRITE_LATENCY = 4,
  parameter int MAX_BEATS     = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         load,
  input  logic                         abort,
  input  logic [$clog2(MAX_BEATS)-1:0] beats_m1,
  input  logic [2:0]                   period,
  output logic                         rd_due,
  output logic                         start_soon,
  output logic                         start_due,
  output logic                         start_last
);

  localparam int CNT_W  = $clog2(WL_MAX + 1);
  localparam int LEFT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0]  rd_cnt;     // cycles until the next read is due
  logic [LEFT_W-1:0] rd_left;    // reads still to issue for this command
  logic [1:0]        st_pipe;    // reads issued 1 and 2 cycles ago
  logic [1:0]        last_pipe;  // same, flagging the final word

  assign rd_due     = (rd_left != '0) && (rd_cnt == '0);
  assign start_soon = st_pipe[0];
  assign start_due  = st_pipe[1];
  assign start_last = last_pipe[1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_cnt    <= '0;
      rd_left   <= '0;
      st_pipe   <= '0;
      last_pipe <= '0;
    end else if (load) begin
      // First counting cycle is cycle 1, so the first read lands at WL-2.
      rd_cnt    <= CNT_W'(WRITE_LATENCY - WL_MIN);
      rd_left   <= LEFT_W'(beats_m1) + LEFT_W'(1);
      st_pipe   <= '0;
      last_pipe <= '0;
    end else if (abort) begin
      rd_left   <= '0;
      st_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      st_pipe   <= {st_pipe[0], rd_due};
      last_pipe <= {last_pipe[0], rd_due && (rd_left == LEFT_W'(1))};
      if (rd_due) begin
        rd_cnt  <= CNT_W'(period) - CNT_W'(1);
        rd_left <= rd_left - LEFT_W'(1);
      end else if (rd_cnt != '0) begin
        rd_cnt <= rd_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_wdata_sequencer.sv
// ddr_wdata_sequencer: accepts one write command, pops its words from the
// write-data pool and loads burst_to_byte with the spacing the DDR
// serialisation needs, WRITE_LATENCY cycles after command acceptance.
// Ports:
//   clk, n_rst             : clock, async active-low reset
//   cmd_valid/cmd_ready    : command handshake; ready only when idle
//   cmd_size, cmd_beats_m1 : bytes per word (1<<size), words minus one
//   pool_empty             : pool has no word to give
//   pool_rd_en             : pop one word; pool_rdata valid next cycle
//   pool_rdata             : pool read data
//   start                  : one-cycle load pulse to burst_to_byte
//   pool_wdata             : word presented to burst_to_byte
//   burst_size             : cmd_size latched for the command
//   busy                   : not idle
//   done                   : pulse with the final start
//   underrun               : pulse when a pop is due but the pool is empty
module ddr_wdata_sequencer
  import ddr_pkg::*;
#(
  parameter int WRITE_LATENCY = 4,
  parameter int MAX_BEATS     = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_size,
  input  logic [$clog2(MAX_BEATS)-1:0] cmd_beats_m1,
  input  logic                         pool_empty,
  output logic                         pool_rd_en,
  input  logic [63:0]                  pool_rdata,
  output logic                         start,
  output logic [63:0]                  pool_wdata,
  output logic [1:0]                   burst_size,
  output logic                         busy,
  output logic                         done,
  output logic                         underrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LAT   = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0] state;
  logic [1:0] drain_cnt;
  logic       rd_q;
  logic [2:0] period;
  logic       accept;
  logic       rd_due;
  logic       start_soon;
  logic       start_due;
  logic       start_last;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign period    = beat_period(burst_size_t'(burst_size));

  // A pop that finds the pool empty kills the command: no read, and neither
  // this cycle's start nor any later one goes out.
  assign underrun   = busy && rd_due && pool_empty;
  assign pool_rd_en = busy && rd_due && !pool_empty;
  assign start      = (state == S_XFER) && start_due && !underrun;
  assign done       = start && start_last;

  wdata_beat_timer #(
    .WRITE_LATENCY (WRITE_LATENCY),
    .MAX_BEATS     (MAX_BEATS)
  ) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (accept),
    .abort      (underrun),
    .beats_m1   (cmd_beats_m1),
    .period     (period),
    .rd_due     (rd_due),
    .start_soon (start_soon),
    .start_due  (start_due),
    .start_last (start_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      drain_cnt  <= '0;
      burst_size <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_LAT;
            burst_size <= cmd_size;
          end
        end
        S_LAT: begin
          if (underrun)        state <= S_IDLE;
          else if (start_soon) state <= S_XFER;
        end
        S_XFER: begin
          if (underrun) begin
            state <= S_IDLE;
          end else if (done) begin
            // Hold off the next command until the last word has finished
            // serialising: P-1 drain cycles, none when P is 1.
            state     <= (period == 3'd1) ? S_IDLE : S_DRAIN;
            drain_cnt <= 2'(period - 3'd2);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_IDLE;
          else                 drain_cnt <= drain_cnt - 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pool data arrives the cycle after rd_en and is captured at the end of
  // that cycle, so it is presented in the matching start cycle.
  // NOTE: pool_wdata is a visible output, so it is reset even though it is a
  // plain data register; a deeper buffer would be left unreset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_q       <= 1'b0;
      pool_wdata <= '0;
    end else begin
      rd_q <= pool_rd_en;
      if (rd_q) pool_wdata <= pool_rdata;
    end
  end

endmodule

// File: tb/tb_ddr_wdata_sequencer.sv
// Scoreboard bench for ddr_wdata_sequencer. Each command pushes one expected
// record per active cycle (read, start/data/done, underrun, cmd_ready return),
// numbered from its acceptance; a negedge monitor builds the same record from
// the DUT and compares against the queue head.
module tb_ddr_wdata_sequencer;

  localparam int WL = 4;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_size;
  logic [2:0]  cmd_beats_m1;
  logic        pool_empty;
  logic        pool_rd_en;
  logic [63:0] pool_rdata;
  logic        start;
  logic [63:0] pool_wdata;
  logic [1:0]  burst_size;
  logic        busy;
  logic        done;
  logic        underrun;

  ddr_wdata_sequencer #(
    .WRITE_LATENCY (WL),
    .MAX_BEATS     (8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_size     (cmd_size),
    .cmd_beats_m1 (cmd_beats_m1),
    .pool_empty   (pool_empty),
    .pool_rd_en   (pool_rd_en),
    .pool_rdata   (pool_rdata),
    .start        (start),
    .pool_wdata   (pool_wdata),
    .burst_size   (burst_size),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        st;
    logic        dn;
    logic        ur;
    logic        rdy;
    logic [63:0] wd;
    logic [1:0]  sz;
  } ev_t;

  ev_t         exp_q[$];
  logic [63:0] pool_q[$];
  logic [63:0] wv [8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit acc_prev = 1'b0;
  bit rdy_prev = 1'b1;
  bit mon_en   = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected records straight from the schedule: word k starts at WL+k*P and
  // is read at WL+k*P-2; uc (nonzero) is the underrun cycle.
  task automatic push_exp(input int sz, input int bm1, input int uc, input logic [63:0] w [8]);
    int p;
    int n;
    int end_c;
    p = (sz == 3) ? 4 : (sz == 2) ? 2 : 1;
    n = bm1 + 1;
    end_c = (uc != 0) ? uc + 1 : WL + (n - 1) * p + p;
    for (int k = 0; k < n; k++) pool_q.push_back(w[k]);
    for (int c = 1; c <= end_c; c++) begin
      ev_t e;
      e.cyc = c; e.rd = 0; e.st = 0; e.dn = 0; e.wd = '0;
      e.sz  = 2'(sz);
      e.ur  = (c == uc);
      e.rdy = (c == end_c);
      for (int k = 0; k < n; k++) begin
        if ((WL + k * p - 2 == c) && (uc == 0 || c < uc)) e.rd = 1;
        if ((WL + k * p == c) && (uc == 0 || c < uc)) begin
          e.st = 1;
          e.wd = w[k];
          e.dn = (k == n - 1) && (uc == 0);
        end
      end
      if (e.rd || e.st || e.ur || e.rdy) exp_q.push_back(e);
    end
  endtask

  // Monitor: cycle numbering restarts at 1 after every acceptance edge.
  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    cyc   = acc_prev ? 1 : cyc + 1;
    o.cyc = cyc;
    o.rd  = pool_rd_en;
    o.st  = start;
    o.dn  = done;
    o.ur  = underrun;
    o.rdy = cmd_ready && !rdy_prev;
    o.wd  = pool_wdata;
    o.sz  = burst_size;
    if (mon_en && (o.rd || o.st || o.dn || o.ur || o.rdy)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected event: got cyc=%0d rd=%b start=%b done=%b underrun=%b ready=%b, expected no activity",
                 o.cyc, o.rd, o.st, o.dn, o.ur, o.rdy);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != o.cyc || o.rd !== e.rd || o.st !== e.st || o.dn !== e.dn ||
            o.ur !== e.ur || o.rdy !== e.rdy || o.sz !== e.sz ||
            (e.st && o.wd !== e.wd)) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d rd=%b start=%b done=%b underrun=%b ready=%b wdata=%h size=%0d, expected cyc=%0d rd=%b start=%b done=%b underrun=%b ready=%b wdata=%h size=%0d",
                   o.cyc, o.rd, o.st, o.dn, o.ur, o.rdy, o.wd, o.sz,
                   e.cyc, e.rd, e.st, e.dn, e.ur, e.rdy, e.wd, e.sz);
        end
      end
    end
    acc_prev = cmd_valid && cmd_ready;
    rdy_prev = cmd_ready;
  end

  // Pool model: data for a pop appears in the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (pool_rd_en === 1'b1) begin
        @(posedge clk);
        #1;
        if (pool_q.size() != 0) pool_rdata = pool_q.pop_front();
        else                    pool_rdata = 64'hdead_dead_dead_dead;
      end
    end
  end

  task automatic wait_ready();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_ready wait: got 0 for 200 cycles, expected 1");
    end
  endtask

  // Drive a command, hold it until accepted, then scramble the command inputs
  // so any sampling after acceptance shows up as wrong timing or size.
  task automatic issue(input int sz, input int bm1);
    @(posedge clk); #1;
    cmd_valid    = 1'b1;
    cmd_size     = 2'(sz);
    cmd_beats_m1 = 3'(bm1);
    wait_ready();
    @(posedge clk); #1;
    cmd_valid    = 1'b0;
    cmd_size     = 2'($urandom);
    cmd_beats_m1 = 3'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expected events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    pool_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_size     = '0;
    cmd_beats_m1 = '0;
    pool_empty   = 1'b0;
    pool_rdata   = '0;

    #2;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset start", start, 0);
    check("reset pool_rd_en", pool_rd_en, 0);
    check("reset done", done, 0);
    check("reset underrun", underrun, 0);
    check("reset pool_wdata", pool_wdata, 0);
    check("reset burst_size", burst_size, 0);

    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;

    // Size 0, two words: reads 2,3; starts 4,5; done 5; ready 6.
    wv = '{64'h30, 64'h3a, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    push_exp(0, 1, 0, wv);
    issue(0, 1);
    wait_drain();

    // Size 2, six words: starts 4..14 every 2; done 14; ready 16.
    wv = '{64'h0123_4567_89ab_cdef, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
           64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000, 64'h0f0f_f0f0_0f0f_f0f0,
           64'h0, 64'h0};
    push_exp(2, 5, 0, wv);
    issue(2, 5);
    wait_drain();

    // Size 3, eight words: starts 4..32 every 4; done 32; ready 36.
    wv = '{64'he7bc_65a2_55ec_7d4b, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
           64'hffff_ffff_ffff_ffff, 64'ha5a5_a5a5_5a5a_5a5a, 64'h1234_5678_9abc_def0,
           64'hcafe_f00d_dead_beef, 64'h7777_0000_7777_0000};
    push_exp(3, 7, 0, wv);
    issue(3, 7);
    wait_drain();

    // Size 1, four words, pool empties in cycle 5: reads 2,3,4; start 4 only;
    // underrun 5; no done; ready 6.
    wv = '{64'haa01, 64'haa02, 64'haa03, 64'haa04, 64'h0, 64'h0, 64'h0, 64'h0};
    push_exp(1, 3, 5, wv);
    issue(1, 3);
    repeat (4) @(posedge clk);
    #1 pool_empty = 1'b1;
    @(posedge clk);
    #1 pool_empty = 1'b0;
    wait_drain();

    // Reset in cycle 6 of a size-3 burst (a read is due in that cycle).
    wv = '{64'hbeef_0000_0000_0001, 64'hbeef_0000_0000_0002, 64'h0, 64'h0,
           64'h0, 64'h0, 64'h0, 64'h0};
    push_exp(3, 7, 0, wv);
    issue(3, 7);
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset pool_rd_en", pool_rd_en, 1);
    mon_en = 1'b0;
    n_rst  = 1'b0;
    #1;
    check("mid-burst reset start", start, 0);
    check("mid-burst reset done", done, 0);
    check("mid-burst reset busy", busy, 0);
    check("mid-burst reset pool_rd_en", pool_rd_en, 0);
    check("mid-burst reset cmd_ready", cmd_ready, 1);
    check("mid-burst reset pool_wdata", pool_wdata, 0);
    check("mid-burst reset burst_size", burst_size, 0);
    exp_q.delete();
    pool_q.delete();
    @(posedge clk); @(posedge clk); #1;
    n_rst  = 1'b1;
    mon_en = 1'b1;
    wv = '{64'hc0ff_ee00_1234_5678, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    push_exp(0, 0, 0, wv);
    issue(0, 0);
    wait_drain();

    // cmd_valid held across done: second command accepted in the ready cycle
    // (cycle 8 of the first) and starts WL cycles after that.
    wv = '{64'h1111_0000_aaaa_0001, 64'h2222_0000_aaaa_0002, 64'h0, 64'h0,
           64'h0, 64'h0, 64'h0, 64'h0};
    push_exp(2, 1, 0, wv);
    wv = '{64'h5a5a_0000_0000_005a, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    push_exp(0, 0, 0, wv);
    @(posedge clk); #1;
    cmd_valid    = 1'b1;
    cmd_size     = 2'd2;
    cmd_beats_m1 = 3'd1;
    wait_ready();
    @(posedge clk); #1;
    cmd_size     = 2'd0;
    cmd_beats_m1 = 3'd0;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_wdata_sequencer.md
Name: ddr_wdata_sequencer

Overview:
Write-data scheduler that feeds burst_to_byte. It accepts one write command (beat size, beat count), pulls 64-bit words from the write-data pool and pulses burst_to_byte's start input with the correct spacing for the DDR serialisation period. It sits between the command scheduler / write-data pool and the DQ output path, and it enforces write latency relative to command acceptance.

Parameters:
WRITE_LATENCY, 4, cycles from command acceptance to the first start pulse; legal range 3..15.
MAX_BEATS, 8, maximum words per command; fixes cmd_beats_m1 width at 3.

Ports:
clk  in  1  system clock (the n_clk phase is used only inside burst_to_byte)
n_rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  write command valid
cmd_ready  out  1  sequencer idle; command accepted when cmd_valid && cmd_ready
cmd_size  in  2  bytes per word = 1<<cmd_size (0:1B, 1:2B, 2:4B, 3:8B)
cmd_beats_m1  in  3  words in the burst minus 1 (0..7 gives 1..8)
pool_empty  in  1  write-data pool has no word available
pool_rd_en  out  1  pop one word; pool_rdata is valid the following cycle
pool_rdata  in  64  pool read data
start  out  1  one-cycle load pulse to burst_to_byte
pool_wdata  out  64  word presented to burst_to_byte; stable from its start cycle until the next capture
burst_size  out  2  latched cmd_size, held for the whole command
busy  out  1  not idle
done  out  1  one-cycle pulse in the cycle of the final start
underrun  out  1  one-cycle pulse when a pop is due while pool_empty=1

Behaviour:
- Reset values: all registered outputs are 0, state is IDLE. cmd_ready = (state==IDLE), so it reads 1 while in reset.
- Period P (cycles between starts) = 1,1,2,4 for size 0,1,2,3, i.e. max(1, bytes/2), since DDR moves 2 bytes per clk.
- Cycle numbering: acceptance edge ends cycle 0. Word k start is high in cycle WRITE_LATENCY + k*P. Word k pool_rd_en is high exactly 2 cycles earlier.
- Capture path: pool_rdata is registered into pool_wdata at the end of the cycle after rd_en, so it is valid in the start cycle.
- States:
  - IDLE: on accept, latch size and beat count, go to LAT.
  - LAT: count WRITE_LATENCY-1 cycles, issuing reads on schedule, then go to XFER.
  - XFER: issue starts and reads per schedule; move to DRAIN after the last start.
  - DRAIN: wait P-1 cycles, then go to IDLE.
  - Net effect: cmd_ready returns in cycle last_start + P. For P=1, DRAIN is skipped and IDLE is next.
- Underrun: pool_empty is sampled in each cycle where a pop is due.
  - If set: no rd_en, underrun=1, and that cycle's start plus all later starts are suppressed. Words already read are discarded.
  - done is not asserted; state goes to IDLE next cycle.
- busy = !cmd_ready. cmd_valid is ignored while busy. Command inputs are sampled only at acceptance.
- Async reset mid-burst: everything clears immediately and no further start is issued. The pool is not rewound; that is the caller's responsibility.
- Simultaneous done and new cmd_valid: the command is not accepted until cmd_ready rises.

Decomposition:
- ddr_pkg:
  - burst_size_t enum (BS_1B, BS_2B, BS_4B, BS_8B)
  - function beat_period(burst_size_t) returning 1/1/2/4
  - WRITE_LATENCY legal bounds
- One sub-module, wdata_beat_timer: latency and period down-counter plus beat counter. It produces rd_due and start_due strobes for the FSM.

Test Plan:
- size0, beats_m1=1, WL=4, pool data 0x30,0x3a -> rd_en in cycles 2,3; start in 4,5 with pool_wdata 0x30 then 0x3a; done in 5; cmd_ready in 6.
- size2, beats_m1=5 -> starts in 4,6,8,10,12,14; rd_en in 2,4,...,12; burst_size=2 held throughout; done in 14; cmd_ready in 16.
- size3, beats_m1=7, data 0xe7bc65a255ec7d4b first -> starts every 4 cycles, 4..32; first pool_wdata matches; done in 32; cmd_ready in 36.
- size1, beats_m1=3, pool_empty raised in cycle 5 -> rd_en in 2,3,4; start in 4 only; underrun in 5; no done; cmd_ready in 6.
- Reset asserted in cycle 6 of a size3 burst -> start/done/busy/pool_rd_en are 0 immediately; after release, a new size0 command completes normally.
- cmd_valid held high across done -> second command accepted only in the first cycle with cmd_ready=1; its first start is WRITE_LATENCY cycles later.
